// File: rtl/run_length_monitor_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | run_length_monitor_pkg : shared state encoding and default widths |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package run_length_monitor_pkg;

    localparam int c_CNT_W = 8;
    localparam int c_LEN_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LONG = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_inc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_inc : conditional increment that holds at all-ones            |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module sat_inc #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic [W-1:0] o_value
);

    assign o_value = (i_en && (i_value != {W{1'b1}})) ? i_value + W'(1) : i_value;

endmodule
`default_nettype wire

// File: rtl/run_length_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | run_length_monitor : run statistics and sticky alarm on match z   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module run_length_monitor
    import run_length_monitor_pkg::*;
#(
    parameter int CNT_W     = c_CNT_W,
    parameter int LEN_W     = c_LEN_W,
    parameter int ALARM_LEN = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             z,
    input  logic             clr,
    output logic             busy,
    output logic [CNT_W-1:0] run_count,
    output logic [LEN_W-1:0] cur_len,
    output logic [LEN_W-1:0] last_len,
    output logic [LEN_W-1:0] max_len,
    output logic             run_done,
    output logic             alarm
);

    localparam logic [LEN_W-1:0] c_ALARM_LEN = LEN_W'(ALARM_LEN);

    state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_run_count, w_run_count_nxt;
    logic [LEN_W-1:0]   r_cur_len,   w_cur_len_nxt;
    logic [LEN_W-1:0]   r_last_len,  w_last_len_nxt;
    logic [LEN_W-1:0]   r_max_len,   w_max_len_nxt;
    logic               r_run_done,  w_run_done_nxt;
    logic               r_alarm,     w_alarm_nxt;

    logic               w_start;
    logic [CNT_W-1:0]   w_run_count_inc;
    logic [LEN_W-1:0]   w_cur_len_inc;

    assign w_start = (r_state == IDLE) && z;

    sat_inc #(.W(CNT_W)) u_run_count_inc (
        .i_value (r_run_count),
        .i_en    (w_start),
        .o_value (w_run_count_inc)
    );

    sat_inc #(.W(LEN_W)) u_cur_len_inc (
        .i_value (r_cur_len),
        .i_en    (z),
        .o_value (w_cur_len_inc)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= IDLE;
            r_run_count <= '0;
            r_cur_len   <= '0;
            r_last_len  <= '0;
            r_max_len   <= '0;
            r_run_done  <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_count <= w_run_count_nxt;
            r_cur_len   <= w_cur_len_nxt;
            r_last_len  <= w_last_len_nxt;
            r_max_len   <= w_max_len_nxt;
            r_run_done  <= w_run_done_nxt;
            r_alarm     <= w_alarm_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_run_count_nxt = r_run_count;
        w_cur_len_nxt   = r_cur_len;
        w_last_len_nxt  = r_last_len;
        w_max_len_nxt   = r_max_len;
        w_run_done_nxt  = 1'b0;
        w_alarm_nxt     = r_alarm;

        if (clr) begin
            w_state_nxt     = IDLE;
            w_run_count_nxt = '0;
            w_cur_len_nxt   = '0;
            w_last_len_nxt  = '0;
            w_max_len_nxt   = '0;
            w_alarm_nxt     = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (z) begin
                        w_state_nxt     = RUN;
                        w_cur_len_nxt   = LEN_W'(1);
                        w_run_count_nxt = w_run_count_inc;
                    end
                end
                RUN, LONG: begin
                    if (z) begin
                        w_cur_len_nxt = w_cur_len_inc;
                        // LONG only tracks length; alarm is already latched
                        if ((r_state == RUN) && (w_cur_len_inc >= c_ALARM_LEN)) begin
                            w_state_nxt = LONG;
                            w_alarm_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt    = IDLE;
                        w_last_len_nxt = r_cur_len;
                        w_max_len_nxt  = (r_cur_len > r_max_len) ? r_cur_len : r_max_len;
                        w_cur_len_nxt  = '0;
                        w_run_done_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign run_count = r_run_count;
    assign cur_len   = r_cur_len;
    assign last_len  = r_last_len;
    assign max_len   = r_max_len;
    assign run_done  = r_run_done;
    assign alarm     = r_alarm;

endmodule
`default_nettype wire
